// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational alu between two requesters.
// Latches the winner's operands, holds them ALU_WAIT cycles, then returns the result with a done pulse.
module alu_arbiter #(
    parameter int DATA_W   = 8,
    parameter int C_W      = 5,
    parameter int SEL_W    = 2,
    parameter int ALU_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [C_W-1:0]    c0,
    input  logic [SEL_W-1:0]  sel0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [C_W-1:0]    c1,
    input  logic [SEL_W-1:0]  sel1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W:0]   result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [C_W-1:0]    alu_c,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W:0]   alu_res
);

    localparam int CNT_W = (ALU_WAIT > 1) ? $clog2(ALU_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             win;

    // On a tie the requester that was not served last wins.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 2'b00;
            busy    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            result  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_c   <= '0;
            alu_sel <= '0;
            cnt     <= '0;
            last    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state   <= WAIT;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        last    <= win;
                        gnt     <= win ? 2'b10 : 2'b01;
                        alu_a   <= win ? a1 : a0;
                        alu_b   <= win ? b1 : b0;
                        alu_c   <= win ? c1 : c0;
                        alu_sel <= win ? sel1 : sel0;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        result <= alu_res;
                        done0  <= gnt[0];
                        done1  <= gnt[1];
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: two instances (ALU_WAIT=1 and ALU_WAIT=4) with a bench-side alu model.
// Stimulus pushes expected results/grant order into queues; a negedge monitor pops and compares.
module tb_alu_arbiter;

    localparam int DW  = 8;
    localparam int CW  = 5;
    localparam int SW  = 2;
    localparam int AW0 = 1;
    localparam int AW1 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    req0, req1;
    logic [DW-1:0] a0 [2], b0 [2], a1 [2], b1 [2];
    logic [CW-1:0] c0 [2], c1 [2];
    logic [SW-1:0] sel0 [2], sel1 [2];
    logic [1:0]    gnt [2];
    logic [1:0]    busy, done0, done1;
    logic [DW:0]   result [2], alu_res [2];
    logic [DW-1:0] alu_a [2], alu_b [2];
    logic [CW-1:0] alu_c [2];
    logic [SW-1:0] alu_sel [2];

    function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [CW-1:0] c, input logic [SW-1:0] s);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a} >> c[2:0];
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_arbiter #(
            .DATA_W(DW), .C_W(CW), .SEL_W(SW), .ALU_WAIT((g == 0) ? AW0 : AW1)
        ) dut (
            .clk(clk), .rst(rst),
            .req0(req0[g]), .a0(a0[g]), .b0(b0[g]), .c0(c0[g]), .sel0(sel0[g]),
            .req1(req1[g]), .a1(a1[g]), .b1(b1[g]), .c1(c1[g]), .sel1(sel1[g]),
            .gnt(gnt[g]), .busy(busy[g]), .done0(done0[g]), .done1(done1[g]),
            .result(result[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]), .alu_c(alu_c[g]),
            .alu_sel(alu_sel[g]), .alu_res(alu_res[g])
        );
        assign alu_res[g] = alu_fn(alu_a[g], alu_b[g], alu_c[g], alu_sel[g]);
    end

    int          tests = 0;
    int          fails = 0;
    logic [DW:0] exp_q [4][$];
    int          ord_q [2][$];
    int          model_last [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: grant order, done pulse shape, latency and result.
    logic [1:0] gprev [2];
    logic       dprev [2];
    int         cyc [2];
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                gprev[g] = 2'b00;
                dprev[g] = 1'b0;
            end else begin
                if (gnt[g] != 2'b00) cyc[g]++;
                if (gnt[g] != 2'b00 && gprev[g] == 2'b00) begin
                    cyc[g] = 0;
                    if (ord_q[g].size() == 0) check("unexpected_grant", gnt[g], 0);
                    else check("grant_order", gnt[g], (ord_q[g].pop_front() == 1) ? 2 : 1);
                end
                if (done0[g] || done1[g]) begin
                    automatic int r = done1[g] ? 1 : 0;
                    check("done_onehot", {done1[g], done0[g]}, r ? 2 : 1);
                    check("done_gnt", gnt[g], r ? 2 : 1);
                    check("done_busy", busy[g], 1);
                    check("done_latency", cyc[g], (g == 0) ? AW0 : AW1);
                    check("done_pulse", dprev[g], 0);
                    if (exp_q[g*2+r].size() == 0) check("unexpected_done", {done1[g], done0[g]}, 0);
                    else check("result", result[g], exp_q[g*2+r].pop_front());
                end
                gprev[g] = gnt[g];
                dprev[g] = done0[g] | done1[g];
            end
        end
    end

    task automatic issue(input int g, input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] c, input logic [SW-1:0] s);
        if (r == 0) begin
            a0[g] = a; b0[g] = b; c0[g] = c; sel0[g] = s; req0[g] = 1'b1;
        end else begin
            a1[g] = a; b1[g] = b; c1[g] = c; sel1[g] = s; req1[g] = 1'b1;
        end
        exp_q[g*2+r].push_back(alu_fn(a, b, c, s));
    endtask

    task automatic issue_rnd(input int g, input int r);
        issue(g, r, DW'($urandom), DW'($urandom), CW'($urandom), SW'($urandom));
    endtask

    // Reference arbitration: a lone requester is served; on a tie the one not served last goes first.
    task automatic expect_order(input int g, input logic [1:0] m);
        if (m == 2'b11) begin
            automatic int first = 1 - model_last[g];
            ord_q[g].push_back(first);
            ord_q[g].push_back(1 - first);
            model_last[g] = 1 - first;
        end else if (m != 2'b00) begin
            ord_q[g].push_back(m[1] ? 1 : 0);
            model_last[g] = m[1] ? 1 : 0;
        end
    endtask

    task automatic serve(input int g, input logic [1:0] m, input int budget);
        automatic logic [1:0] pend = m;
        automatic int n = 0;
        while (pend != 2'b00 && n < budget) begin
            @(negedge clk);
            n++;
            if (pend[0] && done0[g]) begin pend[0] = 1'b0; req0[g] = 1'b0; end
            if (pend[1] && done1[g]) begin pend[1] = 1'b0; req1[g] = 1'b0; end
        end
        if (pend != 2'b00) begin
            check("serve_timeout", pend, 0);
            req0[g] = 1'b0;
            req1[g] = 1'b0;
        end
    endtask

    task automatic check_reset(input int g);
        check("rst_gnt", gnt[g], 0);
        check("rst_busy", busy[g], 0);
        check("rst_done", {done1[g], done0[g]}, 0);
        check("rst_result", result[g], 0);
        check("rst_alu_a", alu_a[g], 0);
        check("rst_alu_b", alu_b[g], 0);
        check("rst_alu_c", alu_c[g], 0);
        check("rst_alu_sel", alu_sel[g], 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last[0] = 1;
        model_last[1] = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d, expected %0d", 1, 0);
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1;
        req0 = 2'b00;
        req1 = 2'b00;
        for (int g = 0; g < 2; g++) begin
            a0[g] = '0; b0[g] = '0; c0[g] = '0; sel0[g] = '0;
            a1[g] = '0; b1[g] = '0; c1[g] = '0; sel1[g] = '0;
            cyc[g] = 0;
            model_last[g] = 1;
        end

        // Reset with req0 pending: everything stays cleared, then req0 is served.
        issue(0, 0, 8'd17, 8'd3, 5'd0, 2'd0);
        expect_order(0, 2'b01);
        repeat (2) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        serve(0, 2'b01, 20);
        repeat (2) @(negedge clk);

        // Lone req0: 200+100 = 300, grant one edge after the request.
        issue(0, 0, 8'd200, 8'd100, 5'd0, 2'd0);
        expect_order(0, 2'b01);
        @(negedge clk);
        check("t2_gnt_next_cycle", gnt[0], 2'b01);
        serve(0, 2'b01, 20);
        repeat (2) @(negedge clk);

        // Simultaneous requests from reset: req0 first, then req1 (5-9 = 9'h1FC); repeat flips order.
        pulse_reset();
        issue(0, 0, 8'd10, 8'd20, 5'd0, 2'd0);
        issue(0, 1, 8'd5, 8'd9, 5'd0, 2'd1);
        expect_order(0, 2'b11);
        serve(0, 2'b11, 40);
        repeat (2) @(negedge clk);
        issue(0, 0, 8'hF0, 8'h3C, 5'd0, 2'd2);
        issue(0, 1, 8'h80, 8'd0, 5'd3, 2'd3);
        expect_order(0, 2'b11);
        serve(0, 2'b11, 40);
        repeat (2) @(negedge clk);

        // Both held continuously for 10 ops: grants must alternate.
        begin
            automatic int first = 1 - model_last[0];
            automatic int issued = 2;
            automatic int served = 0;
            automatic int n = 0;
            automatic logic [1:0] rer = 2'b00;
            for (int k = 0; k < 10; k++) ord_q[0].push_back((k % 2 == 0) ? first : 1 - first);
            model_last[0] = 1 - first;
            issue_rnd(0, 0);
            issue_rnd(0, 1);
            while (served < 10 && n < 200) begin
                @(negedge clk);
                n++;
                for (int r = 0; r < 2; r++) begin
                    if (rer[r]) begin
                        rer[r] = 1'b0;
                        issue_rnd(0, r);
                    end
                end
                if (done0[0]) begin
                    served++; req0[0] = 1'b0;
                    if (issued < 10) begin rer[0] = 1'b1; issued++; end
                end
                if (done1[0]) begin
                    served++; req1[0] = 1'b0;
                    if (issued < 10) begin rer[1] = 1'b1; issued++; end
                end
            end
            check("t4_served", served, 10);
            req0[0] = 1'b0;
            req1[0] = 1'b0;
        end
        repeat (2) @(negedge clk);

        // Random rounds on both instances.
        for (int k = 0; k < 24; k++) begin
            automatic int g = k % 2;
            automatic logic [1:0] m = 2'($urandom_range(1, 3));
            if (m[0]) issue_rnd(g, 0);
            if (m[1]) issue_rnd(g, 1);
            expect_order(g, m);
            serve(g, m, 60);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // Reset in the middle of WAIT (ALU_WAIT=4): op aborted, then req1 completes normally.
        issue(1, 0, 8'd99, 8'd1, 5'd0, 2'd0);
        expect_order(1, 2'b01);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        req0[1] = 1'b0;
        exp_q[2].delete();
        model_last[0] = 1;
        model_last[1] = 1;
        @(negedge clk);
        check_reset(1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_no_done", {done1[1], done0[1]}, 0);
        issue(1, 1, 8'd60, 8'd70, 5'd0, 2'd0);
        expect_order(1, 2'b10);
        serve(1, 2'b10, 30);
        repeat (2) @(negedge clk);

        // Operands changed and req dropped after grant: latched op still completes.
        issue(1, 0, 8'd77, 8'd33, 5'd0, 2'd0);
        expect_order(1, 2'b01);
        @(negedge clk);
        check("t6_gnt", gnt[1], 2'b01);
        a0[1] = '0; b0[1] = '0; sel0[1] = 2'd2; req0[1] = 1'b0;
        serve(1, 2'b01, 30);
        check("t6_alu_a_held", alu_a[1], 77);
        repeat (3) @(negedge clk);

        check("exp_drained", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
        check("ord_drained", ord_q[0].size() + ord_q[1].size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
